// File: rtl/imem_loader_pkg.sv
// Shared CPU package: loader FSM states and depth constants.
// Imported by the instruction-memory loader.
package imem_loader_pkg;

  localparam int LOADER_ADDR_WIDTH = 8;
  localparam int LOADER_DEPTH = 1 << LOADER_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the CPU
// in reset, then releases it for one cycle and raises start.
// Ports: clock/reset (async, active-high); load_req restarts a
// session; word_valid/word_data/word_last + word_ready stream words;
// imem_we/imem_addr/imem_wdata drive the memory one cycle later;
// cpu_reset/start control the CPU; word_count counts writes;
// overflow_err is sticky until load_req or reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic                  word_valid,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  start,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow_err
);

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [ADDR_WIDTH:0] CNT_MAX =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  hs;

  // load_req has priority: a restart cycle never accepts a word.
  assign word_ready = (state == ST_LOAD) && !load_req;
  assign hs = word_valid && word_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      start        <= 1'b0;
      word_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (load_req) begin
            state        <= ST_LOAD;
            ptr          <= '0;
            word_count   <= '0;
            overflow_err <= 1'b0;
            cpu_reset    <= 1'b1;
            start        <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_req) begin
            ptr        <= '0;
            word_count <= '0;
          end else if (hs) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= word_data;
            if (word_count != CNT_MAX)
              word_count <= word_count + 1'b1;
            // Pointer parks at the top word instead of wrapping.
            if (ptr != PTR_MAX)
              ptr <= ptr + 1'b1;
            if (word_last) begin
              state     <= ST_RELEASE;
              cpu_reset <= 1'b0;
            end else if (ptr == PTR_MAX) begin
              state        <= ST_ERROR;
              overflow_err <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          state <= ST_RUN;
          start <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          cpu_reset <= 1'b1;
          start     <= 1'b0;
        end
      endcase
    end
  end

endmodule
